// File: rtl/ripple_pkg_sar.sv
// rtl/ripple_pkg_sar.sv - shared width default and FSM state encodings
//
// Purpose: common definitions for ripple_borrow_counter_sar and its bit stage.
//   RIPPLE_WIDTH_DEFAULT : default counter width
//   state_e              : IDLE/RUN/DONE, 2-bit encodings 00/01/10
package ripple_pkg_sar;

  localparam int RIPPLE_WIDTH_DEFAULT = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/borrow_stage_sar.sv
// rtl/borrow_stage_sar.sv - one bit of the ripple-borrow down counter
//
// Purpose: a single registered counter bit. A load overrides counting; when
// borrow_i is high the bit toggles and passes a borrow upward if it was 0.
// Ports:
//   clk        : system clock, rising edge
//   rst        : asynchronous active-high reset, clears the bit
//   load_i     : load load_bit_i on the next edge
//   load_bit_i : value to load
//   borrow_i   : borrow from the bit below (bit 0: decrement enable)
//   borrow_o   : borrow to the bit above
//   bit_o      : registered bit value
module borrow_stage_sar (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  input  logic load_bit_i,
  input  logic borrow_i,
  output logic borrow_o,
  output logic bit_o
);

  logic bit_q;
  logic bit_d;

  always_comb begin
    bit_d = bit_q;
    if (load_i) begin
      bit_d = load_bit_i;
    end else if (borrow_i) begin
      bit_d = ~bit_q;
    end
  end

  // Subtracting 1 from a 0 bit needs a borrow from the next bit up.
  assign borrow_o = borrow_i & ~bit_q;
  assign bit_o    = bit_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_q <= 1'b0;
    end else begin
      bit_q <= bit_d;
    end
  end

endmodule

// File: rtl/ripple_borrow_counter_sar.sv
// rtl/ripple_borrow_counter_sar.sv - loadable down counter with IDLE/RUN/DONE control
//
// Purpose: loads load_val on an accepted start, counts down to zero through a
// chain of borrow_stage_sar bits, and pulses done for one cycle at zero.
// Optional feature macro: AUTO_RELOAD_EN -- DONE reloads the captured start
// value and re-enters RUN when it is nonzero (loop left only via stop/reset).
// Ports:
//   clk      : system clock, rising edge
//   reset    : asynchronous active-high reset
//   start    : request to load load_val and begin counting (IDLE only)
//   load_val : start value, captured on the accepted start cycle
//   pause    : hold count while in RUN
//   stop     : abort RUN/DONE back to IDLE, count held
//   q        : current count (registered)
//   busy     : high while in RUN
//   done     : high while in DONE (one-cycle pulse)
//   zero     : combinational, q == 0
module ripple_borrow_counter_sar
  import ripple_pkg_sar::*;
#(
  parameter int WIDTH = RIPPLE_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] load_val,
  input  logic             pause,
  input  logic             stop,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done,
  output logic             zero
);

  state_e           state_q;
  state_e           state_d;
  logic [WIDTH-1:0] reload_q;
  logic [WIDTH-1:0] reload_d;

  logic             load_en;
  logic [WIDTH-1:0] load_data;
  logic             dec_en;
  logic             q_is_one;
  logic [WIDTH:0]   borrow;
  logic             borrow_unused;

  assign zero     = (q == '0);
  assign q_is_one = (q == WIDTH'(1));

  // State and reload register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      reload_q <= '0;
    end else begin
      state_q  <= state_d;
      reload_q <= reload_d;
    end
  end

  // Next state. Stop outranks the terminal count, which outranks pause.
  always_comb begin
    state_d  = state_q;
    reload_d = reload_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          // Captured on every accepted start so a zero start never
          // reloads a stale value.
          reload_d = load_val;
          state_d  = (load_val != '0) ? ST_RUN : ST_DONE;
        end
      end
      ST_RUN: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else if (q_is_one || zero) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else begin
`ifdef AUTO_RELOAD_EN
          state_d = (reload_q != '0) ? ST_RUN : ST_IDLE;
`else
          state_d = ST_IDLE;
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs and datapath controls.
  always_comb begin
    busy      = (state_q == ST_RUN);
    done      = (state_q == ST_DONE);
    load_en   = 1'b0;
    load_data = load_val;
    dec_en    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        load_en = start;
      end
      ST_RUN: begin
        // The final 1->0 step happens even under pause; never step below 0.
        if (!stop && !zero && (q_is_one || !pause)) begin
          dec_en = 1'b1;
        end
      end
      ST_DONE: begin
`ifdef AUTO_RELOAD_EN
        if (!stop && (reload_q != '0)) begin
          load_en   = 1'b1;
          load_data = reload_q;
        end
`endif
      end
      default: ;
    endcase
  end

  assign borrow[0] = dec_en;

  genvar i;
  for (i = 0; i < WIDTH; i++) begin : g_stage
    borrow_stage_sar u_stage (
      .clk        (clk),
      .rst        (reset),
      .load_i     (load_en),
      .load_bit_i (load_data[i]),
      .borrow_i   (borrow[i]),
      .borrow_o   (borrow[i+1]),
      .bit_o      (q[i])
    );
  end

  // Decrement is never enabled at zero, so the borrow out of the top bit
  // carries no information.
  assign borrow_unused = borrow[WIDTH];

endmodule

// File: doc/ripple_borrow_counter_sar.md
RIPPLE_BORROW_COUNTER_SAR -- requirements
Module: ripple_borrow_counter_sar

Interface
REQ-001 Parameter WIDTH, default 4, counter width in bits.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset; one clock domain only.
REQ-004 start  input  1  level-sampled request to load load_val and begin counting down.
REQ-005 load_val  input  WIDTH  start value, captured on the accepted start cycle.
REQ-006 pause  input  1  holds q while in RUN.
REQ-007 stop  input  1  aborts RUN/DONE, returns to IDLE.
REQ-008 q  output  WIDTH  current count, registered.
REQ-009 busy  output  1  high exactly while state is RUN.
REQ-010 done  output  1  registered, high exactly while state is DONE.
REQ-011 zero  output  1  combinational, high when q == 0.

Function
REQ-012 The block SHALL implement states IDLE, RUN and DONE.
REQ-013 In IDLE with start=1 and load_val != 0, the next edge SHALL set q=load_val, capture load_val into a reload register, and enter RUN.
REQ-014 In IDLE with start=1 and load_val == 0, the next edge SHALL set q=0 and enter DONE directly.
REQ-015 In IDLE with start=0, q SHALL hold its value.
REQ-016 In RUN with pause=0 and stop=0, q SHALL decrement by 1 per clock via a borrow chain from bit 0 upward.
REQ-017 In RUN with pause=1 and stop=0, q SHALL hold.
REQ-018 In RUN, the edge that takes q from 1 to 0 SHALL also enter DONE; q SHALL never wrap below 0.
REQ-019 start SHALL be ignored in RUN and DONE; no restart mid-count.
REQ-020 stop=1 in RUN or DONE SHALL enter IDLE on the next edge with q held and no done produced.
REQ-021 Priority SHALL be reset > stop > terminal count > pause.
REQ-022 DONE SHALL last exactly one cycle (done one-cycle pulse), then exit per REQ-027/REQ-028.
REQ-023 Latency from accepted start to done high SHALL be load_val+1 clocks when pause is never asserted.

Reset
REQ-024 reset=1 SHALL immediately force state IDLE, q=0, reload register=0, busy=0, done=0, and zero=1, without waiting for clk.
REQ-025 reset asserted mid-RUN or in DONE SHALL abort with no done pulse.
REQ-026 After reset deasserts, the first start SHALL be accepted on the first following rising edge.

Configuration
REQ-027 Without AUTO_RELOAD_EN defined, DONE SHALL always go to IDLE.
REQ-028 With AUTO_RELOAD_EN defined, DONE SHALL load q from the reload register and return to RUN if it is nonzero, otherwise go to IDLE; the loop exits only via stop or reset.

Structure
REQ-029 The shared package ripple_pkg_sar SHALL hold the WIDTH default and the IDLE/RUN/DONE state encodings (2-bit: 00/01/10).
REQ-030 A sub-module borrow_stage_sar SHALL implement one counter bit: registered bit, borrow-in, borrow-out and load; the top level SHALL instantiate WIDTH of them in a chain.

Verification
REQ-031 Reset, then start with load_val=5 -> q=5,4,3,2,1,0 on consecutive edges; done high for one cycle on the edge q reaches 0; busy high during 5,4,3,2,1.
REQ-032 Start with load_val=0 -> DONE on the next edge, q=0, busy never high, one-cycle done.
REQ-033 load_val=15, pause high for 3 cycles at q=9 -> q holds 9 for 3 cycles, done at clock 19 after start.
REQ-034 load_val=8, stop=1 at q=3 -> IDLE next edge, q=3 held, no done; start with load_val=2 then counts 2,1,0.
REQ-035 load_val=12, reset pulsed between edges at q=6 -> q=0, busy=0 immediately; no done pulse.
REQ-036 AUTO_RELOAD_EN defined, load_val=3 -> q=3,2,1,0,3,2,1,0..., done pulse every 4 cycles until stop.
